alu_uart_interface: RTL and testbench

//  Sequencer between the UART receiver/transmitter and the combinational ALU.

---
 rtl/alu_uart_interface_pkg.sv | 21 ++
 rtl/alu_uart_interface_frame_timeout_ctr.sv | 30 +++
 rtl/alu_uart_interface.sv | 92 +++++++++
 tb/tb_alu_uart_interface.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the UART/ALU sequencer: FSM states and ALU opcode constants.
package alu_uart_interface_pkg;

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   localparam logic [7:0] OP_ADD = 8'h20;
   localparam logic [7:0] OP_SUB = 8'h22;
   localparam logic [7:0] OP_AND = 8'h24;
   localparam logic [7:0] OP_OR  = 8'h25;
   localparam logic [7:0] OP_XOR = 8'h26;
   localparam logic [7:0] OP_SRA = 8'h03;
   localparam logic [7:0] OP_SRL = 8'h02;
   localparam logic [7:0] OP_NOR = 8'h27;

endpackage

// File: rtl/alu_uart_interface_frame_timeout_ctr.sv
// Inter-byte idle counter; expired flags the last idle cycle before a partial frame is aborted.
module frame_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || !enable || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // A byte arriving in the expiry cycle takes precedence over the abort.
   assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/alu_uart_interface.sv
// Sequences three UART bytes (A, B, opcode) into the ALU and hands the result to UART TX.
module alu_uart_interface
   import alu_uart_interface_pkg::*;
#(
   parameter int unsigned DATA_LENGTH    = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_LENGTH-1:0] rx_data,
   input  logic                   rx_done,
   input  logic [DATA_LENGTH-1:0] alu_result,
   input  logic                   tx_done,
   output logic [DATA_LENGTH-1:0] A_out,
   output logic [DATA_LENGTH-1:0] B_out,
   output logic [DATA_LENGTH-1:0] Op_code_out,
   output logic [DATA_LENGTH-1:0] tx_data,
   output logic                   tx_start,
   output logic                   err_overrun,
   output logic                   err_timeout
);

   state_t state;
   logic   collecting;
   logic   expired;

   assign collecting = (state == WAIT_B) || (state == WAIT_OP);

   frame_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (rx_done),
      .enable  (collecting),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= WAIT_A;
         A_out       <= '0;
         B_out       <= '0;
         Op_code_out <= '0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         tx_start    <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            WAIT_A: begin
               if (rx_done) begin
                  A_out <= rx_data;
                  state <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (rx_done) begin
                  B_out <= rx_data;
                  state <= WAIT_OP;
               end else if (expired) begin
                  err_timeout <= 1'b1;
                  state       <= WAIT_A;
               end
            end
            WAIT_OP: begin
               if (rx_done) begin
                  Op_code_out <= rx_data;
                  state       <= SEND;
               end else if (expired) begin
                  err_timeout <= 1'b1;
                  state       <= WAIT_A;
               end
            end
            SEND: begin
               tx_data  <= alu_result;
               tx_start <= 1'b1;
               state    <= WAIT_TX;
               if (rx_done) err_overrun <= 1'b1;
            end
            WAIT_TX: begin
               if (rx_done) err_overrun <= 1'b1;
               if (tx_done) state <= WAIT_A;
            end
            default: state <= WAIT_A;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: directed frames plus randomized traffic against a frame-level model.
module tb_alu_uart_interface;
   import alu_uart_interface_pkg::*;

   localparam int unsigned DL = 8;
   localparam int unsigned TO = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DL-1:0] rx_data = '0;
   logic          rx_done = 1'b0;
   logic          tx_done = 1'b0;
   logic [DL-1:0] alu_result;
   logic [DL-1:0] A_out, B_out, Op_code_out, tx_data;
   logic          tx_start, err_overrun, err_timeout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SRA:  return 8'($signed(a) >>> b);
         OP_SRL:  return a >> b;
         OP_NOR:  return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result = alu_fn(A_out, B_out, Op_code_out);

   alu_uart_interface #(
      .DATA_LENGTH(DL),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
      .alu_result(alu_result), .tx_done(tx_done),
      .A_out(A_out), .B_out(B_out), .Op_code_out(Op_code_out),
      .tx_data(tx_data), .tx_start(tx_start),
      .err_overrun(err_overrun), .err_timeout(err_timeout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: bytes collected so far, a pending result, and whether TX is outstanding.
   logic [7:0] m_a, m_b, m_op, m_tx;
   bit         m_start, m_ovr, m_to;
   int         nbytes, idle;
   bit         send_pending, tx_wait;
   bit         model_valid = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
         m_start = 0; m_ovr = 0; m_to = 0;
         nbytes = 0; idle = 0; send_pending = 0; tx_wait = 0;
         model_valid = 1;
      end else begin
         m_start = 0;
         m_to = 0;
         if (send_pending) begin
            m_tx = alu_fn(m_a, m_b, m_op);
            m_start = 1;
            send_pending = 0;
            tx_wait = 1;
            if (rx_done) m_ovr = 1;
         end else if (tx_wait) begin
            if (rx_done) m_ovr = 1;
            if (tx_done) tx_wait = 0;
         end else if (rx_done) begin
            if (nbytes == 0) m_a = rx_data;
            else if (nbytes == 1) m_b = rx_data;
            else begin
               m_op = rx_data;
               send_pending = 1;
            end
            nbytes = (nbytes + 1) % 3;
            idle = 0;
         end else if (nbytes > 0) begin
            idle++;
            if (idle == TO) begin
               nbytes = 0;
               idle = 0;
               m_to = 1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (model_valid) begin
            chk("A_out", A_out, m_a);
            chk("B_out", B_out, m_b);
            chk("Op_code_out", Op_code_out, m_op);
            chk("tx_data", tx_data, m_tx);
            chk("tx_start", tx_start, m_start);
            chk("err_overrun", err_overrun, m_ovr);
            chk("err_timeout", err_timeout, m_to);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic pulse_tx_done();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic wait_start();
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (tx_start) seen = 1;
         else @(negedge clk);
      end
      if (!seen) chk("tx_start_wait", 0, 1);
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      send_byte(a);
      send_byte(b);
      send_byte(op);
   endtask

   initial begin
      int hit;
      int rx_pct;
      logic [7:0] ops [8];
      ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
      ops[4] = OP_XOR; ops[5] = OP_SRA; ops[6] = OP_SRL; ops[7] = OP_NOR;

      repeat (2) @(negedge clk);
      chk("rst_A", A_out, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_overrun", err_overrun, 0);
      chk("rst_timeout", err_timeout, 0);
      rst_n = 1'b1;

      // ADD with exact start latency
      frame(8'h05, 8'h03, OP_ADD);
      chk("add_lat_n1", tx_start, 0);
      @(negedge clk);
      chk("add_lat_n2", tx_start, 1);
      chk("add_result", tx_data, 8'h08);
      chk("model_add", m_tx, 8'h08);
      @(negedge clk);
      chk("add_pulse_len", tx_start, 0);
      pulse_tx_done();

      // SUB wraps negative
      frame(8'h03, 8'h05, OP_SUB);
      wait_start();
      chk("sub_result", tx_data, 8'hFE);
      chk("model_sub", m_tx, 8'hFE);
      pulse_tx_done();

      // Timeout after a lone byte
      send_byte(8'h05);
      hit = -1;
      for (int k = 1; k <= int'(TO) + 3; k++) begin
         @(negedge clk);
         if (err_timeout && hit < 0) hit = k;
      end
      chk("timeout_cycle", hit, TO);
      chk("timeout_keeps_A", A_out, 8'h05);
      frame(8'h01, 8'h02, OP_OR);
      wait_start();
      chk("after_timeout_result", tx_data, 8'h03);
      pulse_tx_done();

      // Overrun during WAIT_TX
      frame(8'h0A, 8'h05, OP_AND);
      wait_start();
      send_byte(8'h77);
      chk("overrun_set", err_overrun, 1);
      chk("overrun_A_kept", A_out, 8'h0A);
      pulse_tx_done();
      chk("overrun_sticky", err_overrun, 1);

      // Reset mid-frame
      send_byte(8'h12);
      send_byte(8'h34);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_A", A_out, 0);
      chk("midrst_B", B_out, 0);
      chk("midrst_overrun", err_overrun, 0);
      frame(8'hF0, 8'h04, OP_SRA);
      wait_start();
      chk("sra_result", tx_data, 8'hFF);
      chk("model_sra", m_tx, 8'hFF);
      pulse_tx_done();

      // Unknown opcode
      frame(8'h11, 8'h22, 8'h3F);
      wait_start();
      chk("unknown_op_start", tx_start, 1);
      chk("unknown_op_result", tx_data, 8'h00);
      pulse_tx_done();

      // Randomized traffic, checked every cycle by the model
      rx_pct = 30;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c % 200 == 0) begin
            case ($urandom_range(0, 2))
               0:       rx_pct = 2;
               1:       rx_pct = 30;
               default: rx_pct = 60;
            endcase
         end
         rx_done = ($urandom_range(0, 99) < rx_pct);
         rx_data = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 7)] : 8'($urandom);
         tx_done = ($urandom_range(0, 99) < 15);
         rst_n   = ($urandom_range(0, 499) != 0);
      end
      @(negedge clk);
      rx_done = 1'b0;
      tx_done = 1'b0;
      rst_n   = 1'b1;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
